// File: rtl/uart_tx_fifo.sv
// Transmit-side byte FIFO feeding a UART transmitter through its din/din_vld/rfd handshake.
// Host writes bursts. Bytes are issued one per frame, and writes into a full FIFO set a sticky overflow flag.
module uart_tx_fifo #(
  parameter int unsigned DI_WIDTH = 8,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DI_WIDTH-1:0]      wr_data,
  input  logic                     wr_en,
  input  logic                     ovf_clr,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DI_WIDTH-1:0]      tx_din,
  output logic                     tx_din_vld,
  input  logic                     tx_rfd
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StBusy} state_e;

  state_e              state_q;
  logic [DI_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       rd_ptr_q;
  logic [AW:0]         level_q;
  logic                overflow_q;
  logic [DI_WIDTH-1:0] tx_din_q;
  logic                tx_din_vld_q;
  logic                pop;
  logic                wr_acc;

  assign empty      = (level_q == '0);
  assign full       = (level_q == (AW+1)'(DEPTH));
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign tx_din     = tx_din_q;
  assign tx_din_vld = tx_din_vld_q;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write then.
  assign pop    = (state_q == StIdle) && !empty && tx_rfd;
  assign wr_acc = wr_en && (!full || pop);

  // Storage is not reset; pointers and level define validity.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({wr_acc, pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
      // A dropped write wins over a simultaneous clear.
      if (wr_en && !wr_acc) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // WAIT/BUSY follow rfd through a full low-then-high cycle so a lagging rfd
  // cannot trigger a second strobe for the same frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      tx_din_q     <= '0;
      tx_din_vld_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            tx_din_q     <= mem[rd_ptr_q];
            tx_din_vld_q <= 1'b1;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          tx_din_vld_q <= 1'b0;
          state_q      <= StWait;
        end
        StWait: begin
          if (!tx_rfd) begin
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (tx_rfd) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q      <= StIdle;
          tx_din_vld_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
